sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one synchronous SRAM port (read data valid one cycle after mem_en)
// between a read-only instruction-fetch port and a load/store data port.
//
// Ports
//   clk, resetn        : clock (rising edge), synchronous active-low reset
//   inst_*             : fetch port. inst_req/inst_addr in, inst_addr_ok out
//                        (combinational grant), inst_data_ok/inst_rdata out,
//                        inst_rsp_ready in
//   data_*             : load/store port. data_req/data_wr/data_wstrb/
//                        data_addr/data_wdata in, data_addr_ok out
//                        (combinational grant), data_data_ok/data_rdata out,
//                        data_rsp_ready in
//   mem_*              : shared SRAM port. mem_en/mem_we/mem_addr/mem_wdata
//                        out, mem_rdata in
//
// Handshake: a request is taken when req=1 and addr_ok=1 in the same cycle.
// A response is taken when data_ok=1 and rsp_ready=1 in the same cycle; while
// rsp_ready=0 the response is parked in that side's hold buffer and data_ok
// stays high with the same rdata until it is taken.
//
// Arbitration: data beats inst, except when inst has lost STARVE_MAX times in
// a row while eligible, in which case inst wins once.
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_rsp_ready,
  // load/store port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        data_rsp_ready,
  // shared SRAM port
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic       SRC_INST   = 1'b0;
  localparam logic       SRC_DATA   = 1'b1;
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  // response stage: the transaction granted last cycle, whose SRAM data
  // appears on mem_rdata this cycle
  logic        rsp_valid;
  logic        rsp_src;
  logic        rsp_wr;

  // per-side hold buffers for responses the owner was not ready to take
  logic        inst_hold_valid;
  logic [31:0] inst_hold_data;
  logic        data_hold_valid;
  logic [31:0] data_hold_data;

  logic [1:0]  starve_cnt;

  logic        inst_rsp_now;
  logic        data_rsp_now;
  logic        inst_busy;
  logic        data_busy;
  logic        inst_elig;
  logic        data_elig;
  logic        starve_hit;
  logic        grant_inst;
  logic        grant_data;

  always_comb begin
    inst_rsp_now = rsp_valid && (rsp_src == SRC_INST);
    data_rsp_now = rsp_valid && (rsp_src == SRC_DATA);

    // A side whose response completes this cycle (rsp_ready=1) is free to be
    // granted again in the same cycle; a parked response always blocks.
    inst_busy = (inst_rsp_now && !inst_rsp_ready) || inst_hold_valid;
    data_busy = (data_rsp_now && !data_rsp_ready) || data_hold_valid;

    inst_elig = inst_req && !inst_busy;
    data_elig = data_req && !data_busy;

    starve_hit = (starve_cnt == STARVE_LIM);

    grant_data = resetn && data_elig && !(inst_elig && starve_hit);
    grant_inst = resetn && inst_elig && !grant_data;
  end

  // request side and SRAM drive
  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    mem_en       = grant_inst || grant_data;
    mem_we       = 4'h0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    if (grant_data) begin
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      if (data_wr) begin
        mem_we = data_wstrb;
      end
    end else if (grant_inst) begin
      mem_addr  = inst_addr;
      mem_wdata = data_wdata;
    end
  end

  // response side
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    if (resetn) begin
      if (inst_hold_valid) begin
        inst_data_ok = 1'b1;
        inst_rdata   = inst_hold_data;
      end else if (inst_rsp_now) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_rdata;
      end
      if (data_hold_valid) begin
        data_data_ok = 1'b1;
        data_rdata   = data_hold_data;
      end else if (data_rsp_now) begin
        data_data_ok = 1'b1;
        // stores return no data
        data_rdata   = rsp_wr ? 32'h0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid       <= 1'b0;
      rsp_src         <= SRC_INST;
      rsp_wr          <= 1'b0;
      inst_hold_valid <= 1'b0;
      inst_hold_data  <= 32'h0;
      data_hold_valid <= 1'b0;
      data_hold_data  <= 32'h0;
      starve_cnt      <= 2'd0;
    end else begin
      rsp_valid <= grant_inst || grant_data;
      rsp_src   <= grant_data ? SRC_DATA : SRC_INST;
      rsp_wr    <= grant_data && data_wr;

      // starve_cnt only counts losses while inst is actually eligible
      if (!inst_req || grant_inst) begin
        starve_cnt <= 2'd0;
      end else if (inst_elig && (starve_cnt != 2'd3)) begin
        starve_cnt <= starve_cnt + 2'd1;
      end

      if (inst_rsp_now && !inst_rsp_ready) begin
        inst_hold_valid <= 1'b1;
        inst_hold_data  <= mem_rdata;
      end else if (inst_hold_valid && inst_rsp_ready) begin
        inst_hold_valid <= 1'b0;
      end

      if (data_rsp_now && !data_rsp_ready) begin
        data_hold_valid <= 1'b1;
        data_hold_data  <= rsp_wr ? 32'h0 : mem_rdata;
      end else if (data_hold_valid && data_rsp_ready) begin
        data_hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural SRAM sits on
// the mem_* port; a transaction-level reference model tracks each side's
// outstanding response and a reference memory to predict every output.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int STARVE_MAX = 3;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_rsp_ready;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        data_rsp_ready;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .inst_rsp_ready (inst_rsp_ready),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_wstrb     (data_wstrb),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .data_rsp_ready (data_rsp_ready),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // behavioural SRAM on the DUT's shared port
  logic [31:0] sram[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    if (sram.exists(a)) return sram[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram_rd(mem_addr);
      if (mem_we != 4'h0) sram[mem_addr] = merge(sram_rd(mem_addr), mem_wdata, mem_we);
    end
  end

  // reference model: per side (0 = inst, 1 = data)
  //   phase 0 = nothing owed, 1 = response due from SRAM this cycle,
  //   2 = response parked, waiting for rsp_ready
  int          ph[2];
  logic [31:0] exp_val[2];
  bit          exp_wr[2];
  int          starve;

  // observed values of the last cycle, for scenario-level checks
  logic        obs_gi, obs_gd, obs_ido, obs_ddo;
  logic [31:0] obs_irdata, obs_drdata, obs_mem_addr;
  logic [3:0]  obs_mem_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already driven (posedge+1). Check mid-cycle, advance model,
  // then move to posedge+1 of the next cycle.
  task automatic do_cycle();
    bit bi, bd, ei, ed, gi, gd;
    logic [31:0] ea;
    #3;
    obs_gi = inst_addr_ok;  obs_gd = data_addr_ok;
    obs_ido = inst_data_ok; obs_ddo = data_data_ok;
    obs_irdata = inst_rdata; obs_drdata = data_rdata;
    obs_mem_addr = mem_addr; obs_mem_we = mem_we;
    gi = 0; gd = 0; ei = 0;
    if (!resetn) begin
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_inst_rdata", inst_rdata, 0);
      chk("rst_data_rdata", data_rdata, 0);
    end else begin
      bi = (ph[0] == 1 && !inst_rsp_ready) || ph[0] == 2;
      bd = (ph[1] == 1 && !data_rsp_ready) || ph[1] == 2;
      ei = inst_req && !bi;
      ed = data_req && !bd;
      gd = ed && !(ei && starve == STARVE_MAX);
      gi = ei && !gd;
      chk("inst_addr_ok", inst_addr_ok, gi);
      chk("data_addr_ok", data_addr_ok, gd);
      chk("mem_en", mem_en, gi | gd);
      chk("mem_we", mem_we, (gd && data_wr) ? data_wstrb : 4'h0);
      if (gi || gd) begin
        ea = gd ? data_addr : inst_addr;
        chk("mem_addr", mem_addr, ea);
      end
      if (gd) chk("mem_wdata", mem_wdata, data_wdata);
      chk("inst_data_ok", inst_data_ok, ph[0] != 0);
      if (ph[0] != 0) chk("inst_rdata", inst_rdata, exp_val[0]);
      chk("data_data_ok", data_data_ok, ph[1] != 0);
      if (ph[1] != 0 && !exp_wr[1]) chk("data_rdata", data_rdata, exp_val[1]);
    end
    // advance the model by one clock edge
    if (!resetn) begin
      ph[0] = 0; ph[1] = 0; starve = 0;
    end else begin
      if (ph[0] != 0) ph[0] = inst_rsp_ready ? 0 : 2;
      if (ph[1] != 0) ph[1] = data_rsp_ready ? 0 : 2;
      if (gi) begin
        ph[0] = 1; exp_val[0] = ref_rd(inst_addr); exp_wr[0] = 0;
      end
      if (gd) begin
        ph[1] = 1; exp_wr[1] = data_wr;
        if (data_wr) ref_mem[data_addr] = merge(ref_rd(data_addr), data_wdata, data_wstrb);
        else exp_val[1] = ref_rd(data_addr);
      end
      if (!inst_req || gi) starve = 0;
      else if (ei && starve < 3) starve++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    resetn = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0; inst_rsp_ready = 1'b1;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; data_rsp_ready = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h1C00_0000 | (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    ph[0] = 0; ph[1] = 0; exp_val[0] = 0; exp_val[1] = 0;
    exp_wr[0] = 0; exp_wr[1] = 0; starve = 0;
    sram[32'h1C00_0000] = 32'h0280_0413; ref_mem[32'h1C00_0000] = 32'h0280_0413;
    sram[32'h1C00_0020] = 32'h1234_5678; ref_mem[32'h1C00_0020] = 32'h1234_5678;

    // reset
    idle_inputs();
    resetn = 1'b0;
    @(posedge clk); #1;
    do_cycle();
    do_cycle();
    resetn = 1'b1;
    do_cycle();

    // fetch: grant in cycle 0, data in cycle 1
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    do_cycle();
    chk("fetch_addr_ok", obs_gi, 1);
    inst_req = 1'b0;
    do_cycle();
    chk("fetch_data_ok", obs_ido, 1);
    chk("fetch_rdata", obs_irdata, 32'h0280_0413);

    // store, then load it back
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h1C00_8000; data_wdata = 32'hDEAD_BEEF;
    do_cycle();
    chk("store_mem_we", obs_mem_we, 4'hF);
    chk("store_mem_addr", obs_mem_addr, 32'h1C00_8000);
    data_req = 1'b0;
    do_cycle();
    chk("store_data_ok", obs_ddo, 1);
    data_req = 1'b1; data_wr = 1'b0;
    do_cycle();
    data_req = 1'b0;
    do_cycle();
    chk("load_back", obs_drdata, 32'hDEAD_BEEF);

    // both held high: d, d, d, i, d
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_addr = 32'h1C00_0010;
    for (int c = 0; c < 5; c++) begin
      do_cycle();
      chk($sformatf("contend_inst_c%0d", c), obs_gi, (c == 3) ? 1 : 0);
      chk($sformatf("contend_data_c%0d", c), obs_gd, (c == 3) ? 0 : 1);
    end
    idle_inputs();
    do_cycle();

    // stalled load: held 4 cycles, inst keeps being served
    data_req = 1'b1; data_addr = 32'h1C00_0020;
    do_cycle();
    chk("stall_grant", obs_gd, 1);
    data_rsp_ready = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0008;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) data_rsp_ready = 1'b1;
      do_cycle();
      chk($sformatf("stall_ok_c%0d", c), obs_ddo, 1);
      chk($sformatf("stall_rdata_c%0d", c), obs_drdata, 32'h1234_5678);
      chk($sformatf("stall_no_dgrant_c%0d", c), obs_gd, 0);
      chk($sformatf("stall_igrant_c%0d", c), obs_gi, 1);
    end
    idle_inputs();
    do_cycle();
    do_cycle();

    // reset right after a grant kills the response
    data_req = 1'b1; data_addr = 32'h1C00_0024;
    do_cycle();
    idle_inputs();
    resetn = 1'b0;
    do_cycle();
    do_cycle();
    resetn = 1'b1;
    do_cycle();
    chk("post_rst_no_ok", obs_ddo, 0);
    do_cycle();
    chk("post_rst_no_ok2", obs_ddo, 0);

    // one-cycle inst pulse while data wins: no lasting starvation credit
    data_req = 1'b1; data_addr = 32'h1C00_0030;
    inst_req = 1'b1; inst_addr = 32'h1C00_000C;
    do_cycle();
    chk("pulse_no_igrant", obs_gi, 0);
    inst_req = 1'b0;
    do_cycle();
    chk("pulse_no_iok", obs_ido, 0);
    do_cycle();
    inst_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      do_cycle();
      chk($sformatf("pulse_after_inst_c%0d", c), obs_gi, (c == 3) ? 1 : 0);
    end
    idle_inputs();
    do_cycle();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      resetn         = ($urandom_range(0, 99) != 0);
      inst_req       = ($urandom_range(0, 9) < 7);
      inst_addr      = rand_addr();
      inst_rsp_ready = ($urandom_range(0, 9) < 7);
      data_req       = ($urandom_range(0, 9) < 6);
      data_wr        = $urandom_range(0, 1) == 1;
      data_wstrb     = 4'($urandom_range(0, 15));
      data_addr      = rand_addr();
      data_wdata     = $urandom;
      data_rsp_ready = ($urandom_range(0, 9) < 7);
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
